// File: rtl/motion_update_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motion_update_ram_sequencer
// Function : Streams records 0..N-1 of a state RAM through a motion-update
//            pipeline and writes the results back in order via a second port.
// Revision : 1.0
// ============================================================================
module motion_update_ram_sequencer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_particles,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic                  ram_wren_a,
    input  logic [WIDTH-1:0]      ram_q_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [WIDTH-1:0]      ram_data_b,
    output logic                  ram_wren_b,
    output logic                  upd_in_valid,
    output logic [WIDTH-1:0]      upd_in_data,
    input  logic                  upd_out_valid,
    input  logic [WIDTH-1:0]      upd_out_data
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_WIDTH:0] r_n;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_outstanding;
    logic                r_rd_issue;
    logic [RD_LAT-1:0]   r_vld;

    logic [ADDR_WIDTH:0] w_n_clamped;
    logic [ADDR_WIDTH:0] w_rd_next;
    logic                w_wr;
    logic                w_overflow;

    assign w_n_clamped = (num_particles > c_depth) ? c_depth : num_particles;
    assign w_rd_next   = r_rd_ptr + c_one;
    // A result with nothing in flight cannot belong to this pass; drop it.
    assign w_wr        = upd_out_valid && (r_outstanding != '0);
    assign w_overflow  = upd_out_valid && (r_outstanding == '0);

    assign ram_wren_a   = 1'b0;
    assign ram_wren_b   = w_wr;
    assign ram_addr_b   = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_data_b   = upd_out_data;
    assign upd_in_valid = r_vld[RD_LAT-1];
    assign upd_in_data  = ram_q_a;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= '0;
            r_rd_issue    <= 1'b0;
            r_vld         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow_err  <= 1'b0;
            ram_addr_a    <= '0;
        end else begin
            r_rd_issue <= 1'b0;
            done       <= 1'b0;
            // Valid tag travels alongside the RAM's address and output registers.
            r_vld      <= RD_LAT'({r_vld, r_rd_issue});

            if (w_overflow) overflow_err <= 1'b1;
            if (w_wr)       r_wr_ptr     <= r_wr_ptr + c_one;

            case ({r_rd_issue, w_wr})
                2'b10:   r_outstanding <= r_outstanding + c_one;
                2'b01:   r_outstanding <= r_outstanding - c_one;
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_n_clamped != '0) begin
                            r_n        <= w_n_clamped;
                            ram_addr_a <= '0;
                            r_rd_issue <= 1'b1;
                            r_rd_ptr   <= c_one;
                            r_wr_ptr   <= '0;
                            r_state    <= (w_n_clamped == c_one) ? S_DRAIN : S_READ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    ram_addr_a <= r_rd_ptr[ADDR_WIDTH-1:0];
                    r_rd_issue <= 1'b1;
                    r_rd_ptr   <= w_rd_next;
                    if (w_rd_next == r_n) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_wr_ptr == r_n) r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motion_update_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_update_ram_sequencer
// Function : Directed bench with RAM and variable-latency update models.
// Revision : 1.0
// ============================================================================
module tb_motion_update_ram_sequencer;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 256;
    localparam int ADDR_WIDTH = 8;
    localparam int RD_LAT     = 2;

    logic                  clock = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH:0]   num_particles;
    logic                  busy, done, overflow_err;
    logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
    logic                  ram_wren_a, ram_wren_b;
    logic [WIDTH-1:0]      ram_q_a, ram_data_b;
    logic                  upd_in_valid, upd_out_valid;
    logic [WIDTH-1:0]      upd_in_data, upd_out_data;

    motion_update_ram_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .rst(rst), .start(start), .num_particles(num_particles),
        .busy(busy), .done(done), .overflow_err(overflow_err),
        .ram_addr_a(ram_addr_a), .ram_wren_a(ram_wren_a), .ram_q_a(ram_q_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
        .upd_in_valid(upd_in_valid), .upd_in_data(upd_in_data),
        .upd_out_valid(upd_out_valid), .upd_out_data(upd_out_data)
    );

    always #5 clock = ~clock;

    // RAM model: registered address then registered output (two-cycle read)
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]      q_reg;
    assign ram_q_a = q_reg;

    always @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'(32'h100 + i);
        end else if (ram_wren_b) begin
            mem[ram_addr_b] <= ram_data_b;
        end
        a_reg <= ram_addr_a;
        q_reg <= mem[a_reg];
    end

    // Update pipeline model: +1, in-order, configurable latency and random stalls
    int               lat = 3;
    bit               gap_mode = 0;
    logic [WIDTH-1:0] pq[$];
    int               pt[$];
    int               mcyc = 0;
    logic             pipe_valid = 1'b0;
    logic [WIDTH-1:0] pipe_data = '0;
    logic             inj_valid;
    logic [WIDTH-1:0] inj_data;

    assign upd_out_valid = pipe_valid | inj_valid;
    assign upd_out_data  = inj_valid ? inj_data : pipe_data;

    always @(posedge clock) begin
        if (upd_in_valid) begin
            pq.push_back(upd_in_data + 16'h1);
            pt.push_back(mcyc + lat);
        end
        if (pq.size() > 0 && pt[0] <= mcyc + 1 && (!gap_mode || $urandom_range(1, 0) == 1)) begin
            pipe_valid <= 1'b1;
            pipe_data  <= pq.pop_front();
            void'(pt.pop_front());
        end else begin
            pipe_valid <= 1'b0;
        end
        mcyc = mcyc + 1;
    end

    // Event monitor
    int               wr_cnt = 0, done_cnt = 0, in_cnt = 0;
    bit               wren_a_seen = 0;
    logic [ADDR_WIDTH-1:0] wr_log[$];

    always @(posedge clock) begin
        if (ram_wren_b) begin
            wr_cnt++;
            wr_log.push_back(ram_addr_b);
        end
        if (done)         done_cnt++;
        if (upd_in_valid) in_cnt++;
        if (ram_wren_a)   wren_a_seen = 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start(input int n);
        @(negedge clock);
        start         = 1'b1;
        num_particles = (ADDR_WIDTH+1)'(n);
        @(negedge clock);
        start         = 1'b0;
    endtask

    logic [WIDTH-1:0] snap [DEPTH];
    int               wr0, done0, in0, bad;

    initial begin
        rst = 1'b1; start = 1'b0; num_particles = '0;
        inj_valid = 1'b0; inj_data = '0;

        // T1: reset
        repeat (3) @(negedge clock);
        check("t1_busy", 32'(busy), 0);
        check("t1_done", 32'(done), 0);
        check("t1_ovf", 32'(overflow_err), 0);
        check("t1_wren_a", 32'(ram_wren_a), 0);
        check("t1_wren_b", 32'(ram_wren_b), 0);
        check("t1_in_valid", 32'(upd_in_valid), 0);
        check("t1_addr_a", 32'(ram_addr_a), 0);
        check("t1_addr_b", 32'(ram_addr_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // T2: N=4, latency 3
        lat = 3; gap_mode = 0;
        wr0 = wr_cnt; done0 = done_cnt; in0 = in_cnt;
        pulse_start(4);
        check("t2_busy_s1", 32'(busy), 1);
        check("t2_addr_s1", 32'(ram_addr_a), 0);
        check("t2_inv_s1", 32'(upd_in_valid), 0);
        @(negedge clock);
        check("t2_addr_s2", 32'(ram_addr_a), 1);
        check("t2_inv_s2", 32'(upd_in_valid), 0);
        @(negedge clock);
        check("t2_addr_s3", 32'(ram_addr_a), 2);
        check("t2_inv_s3", 32'(upd_in_valid), 1);
        check("t2_ind_s3", 32'(upd_in_data), 32'h100);
        @(negedge clock);
        check("t2_addr_s4", 32'(ram_addr_a), 3);
        check("t2_ind_s4", 32'(upd_in_data), 32'h101);
        @(negedge clock);
        check("t2_ind_s5", 32'(upd_in_data), 32'h102);
        @(negedge clock);
        check("t2_inv_s6", 32'(upd_in_valid), 1);
        check("t2_ind_s6", 32'(upd_in_data), 32'h103);
        @(negedge clock);
        check("t2_inv_s7", 32'(upd_in_valid), 0);
        wait_done("t2_done_seen", 100);
        check("t2_busy_at_done", 32'(busy), 0);
        repeat (3) @(negedge clock);
        check("t2_busy_after", 32'(busy), 0);
        check("t2_writes", 32'(wr_cnt - wr0), 4);
        check("t2_done_cnt", 32'(done_cnt - done0), 1);
        check("t2_in_cnt", 32'(in_cnt - in0), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_wr_addr", 32'(wr_log[wr0 + i]), 32'(i));
            check("t2_mem", 32'(mem[i]), 32'(32'h101 + i));
        end
        check("t2_mem4_untouched", 32'(mem[4]), 32'h104);

        // T3: N=0
        wr0 = wr_cnt; in0 = in_cnt;
        pulse_start(0);
        check("t3_done_s1", 32'(done), 0);
        check("t3_busy_s1", 32'(busy), 1);
        @(negedge clock);
        check("t3_done_s2", 32'(done), 1);
        check("t3_busy_s2", 32'(busy), 0);
        @(negedge clock);
        check("t3_done_s3", 32'(done), 0);
        repeat (3) @(negedge clock);
        check("t3_writes", 32'(wr_cnt - wr0), 0);
        check("t3_in_cnt", 32'(in_cnt - in0), 0);

        // T4: N=DEPTH, latency 1, random return gaps
        lat = 1; gap_mode = 1;
        for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
        wr0 = wr_cnt; done0 = done_cnt;
        pulse_start(DEPTH);
        wait_done("t4_done_seen", 3000);
        repeat (3) @(negedge clock);
        check("t4_writes", 32'(wr_cnt - wr0), 32'(DEPTH));
        check("t4_done_cnt", 32'(done_cnt - done0), 1);
        check("t4_ovf", 32'(overflow_err), 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (wr0 + i >= wr_log.size() || wr_log[wr0 + i] !== ADDR_WIDTH'(i)) bad++;
        check("t4_addr_order_bad", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== snap[i] + 16'h1) bad++;
        check("t4_mem_bad", 32'(bad), 0);
        gap_mode = 0;

        // T5: start re-pulse mid-pass ignored
        lat = 2;
        wr0 = wr_cnt; done0 = done_cnt; in0 = in_cnt;
        pulse_start(5);
        @(negedge clock);
        start = 1'b1; num_particles = 9'd7;
        @(negedge clock);
        start = 1'b0;
        wait_done("t5_done_seen", 200);
        repeat (6) @(negedge clock);
        check("t5_writes", 32'(wr_cnt - wr0), 5);
        check("t5_done_cnt", 32'(done_cnt - done0), 1);
        check("t5_in_cnt", 32'(in_cnt - in0), 5);
        check("t5_busy", 32'(busy), 0);

        // T6: stray result in IDLE, then reset mid-pass
        wr0 = wr_cnt;
        @(negedge clock);
        inj_valid = 1'b1; inj_data = 16'hdead;
        check("t6_stray_wren_b", 32'(ram_wren_b), 0);
        @(negedge clock);
        inj_valid = 1'b0;
        check("t6_ovf_set", 32'(overflow_err), 1);
        repeat (4) @(negedge clock);
        check("t6_ovf_sticky", 32'(overflow_err), 1);
        check("t6_stray_writes", 32'(wr_cnt - wr0), 0);

        lat = 3;
        pulse_start(10);
        repeat (3) @(negedge clock);
        check("t6_addr_before_rst", 32'(ram_addr_a), 3);
        rst = 1'b1;
        @(negedge clock);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_ovf", 32'(overflow_err), 0);
        check("t6_rst_addr_a", 32'(ram_addr_a), 0);
        check("t6_rst_in_valid", 32'(upd_in_valid), 0);
        check("t6_rst_wren_b", 32'(ram_wren_b), 0);
        rst = 1'b0;
        wr0 = wr_cnt;
        repeat (8) @(negedge clock);
        check("t6_inflight_ovf", 32'(overflow_err), 1);
        check("t6_inflight_writes", 32'(wr_cnt - wr0), 0);
        check("t6_busy_idle", 32'(busy), 0);

        check("wren_a_never", 32'(wren_a_seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
